// File: rtl/pia8255_pkg.sv
// Shared constants for the pia8255_gen PIA: register addresses, control-word fields,
// mode-1 port C handshake bit positions and the reset control word.
package pia8255_pkg;

  localparam logic [1:0] ADDR_A    = 2'd0;
  localparam logic [1:0] ADDR_B    = 2'd1;
  localparam logic [1:0] ADDR_C    = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int CW_MODESET  = 7;
  localparam int CW_AMODE_HI = 6;
  localparam int CW_AMODE_LO = 5;
  localparam int CW_A_IN     = 4;
  localparam int CW_CH_IN    = 3;
  localparam int CW_B_MODE   = 2;
  localparam int CW_B_IN     = 1;
  localparam int CW_CL_IN    = 0;

  localparam logic [1:0] AMODE_1 = 2'b01;

  localparam logic [2:0] PC_INTR = 3'd3;
  localparam logic [2:0] PC_STB  = 3'd4;
  localparam logic [2:0] PC_IBF  = 3'd5;
  localparam logic [2:0] PC_ACK  = 3'd6;
  localparam logic [2:0] PC_OBF  = 3'd7;

  localparam logic [7:0] CTRL_RESET_DEF = 8'h9B;

  // STB_n (PC4) and ACK_n (PC6) idle high, so their history starts at 1
  localparam logic [7:0] PC_HS_IDLE = 8'h50;

endpackage

// File: rtl/pia_sync.sv
// Optional input synchroniser plus a one-register rise/fall edge detector.
// PIA8255_INSYNC_EN inserts STAGES flops ahead of q; otherwise q follows d directly.
module pia_sync #(
  parameter int           W       = 8,
  parameter int           STAGES  = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

`ifdef PIA8255_INSYNC_EN
  localparam int DEPTH = STAGES;
`else
  localparam int DEPTH = 0 * STAGES;
`endif

  logic [W-1:0] hist;

  if (DEPTH > 0) begin : g_sync
    logic [W-1:0] stage [DEPTH];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end
    assign q = stage[DEPTH-1];
  end else begin : g_direct
    assign q = d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist <= RST_VAL;
    else          hist <= q;
  end

  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/pia8255_gen.sv
// 8255-style three-port PIA with port C bit set/reset and mode-1 strobed handshake on port A.
// Define PIA8255_INSYNC_EN to pass pin inputs through SYNC_STAGES synchroniser flops.
module pia8255_gen
  import pia8255_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CTRL_RESET  = CTRL_RESET_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       we,
  input  logic       rd,
  input  logic [1:0] address,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pa_i,
  input  logic [7:0] pb_i,
  input  logic [7:0] pc_i,
  output logic [7:0] pa_o,
  output logic [7:0] pb_o,
  output logic [7:0] pc_o,
  output logic       pa_oe,
  output logic       pb_oe,
  output logic [7:0] pc_oe,
  output logic       intr_a
);

  logic [7:0] ctrl, pa_lat, pb_lat, pc_lat, a_in_lat;
  logic       inte, intr, ibf, obf_n;
  logic [7:0] pa_s, pb_s, pc_s, pa_rise, pa_fall, pb_rise, pb_fall, pc_rise, pc_fall;
  logic [7:0] pc_own, pc_out, pc_rd;
  logic       mode1, a_in, m1_in, m1_out, wr, ctrl_wr, wr_a, rd_a;
  logic       unused_ok;

  pia_sync #(.W(8), .STAGES(SYNC_STAGES), .RST_VAL(8'h00)) u_sync_a (
    .clk(clk), .reset_n(reset_n), .d(pa_i), .q(pa_s), .rise(pa_rise), .fall(pa_fall));
  pia_sync #(.W(8), .STAGES(SYNC_STAGES), .RST_VAL(8'h00)) u_sync_b (
    .clk(clk), .reset_n(reset_n), .d(pb_i), .q(pb_s), .rise(pb_rise), .fall(pb_fall));
  pia_sync #(.W(8), .STAGES(SYNC_STAGES), .RST_VAL(PC_HS_IDLE)) u_sync_c (
    .clk(clk), .reset_n(reset_n), .d(pc_i), .q(pc_s), .rise(pc_rise), .fall(pc_fall));

  assign mode1   = ctrl[CW_AMODE_HI:CW_AMODE_LO] == AMODE_1;
  assign a_in    = ctrl[CW_A_IN];
  assign m1_in   = mode1 & a_in;
  assign m1_out  = mode1 & ~a_in;
  assign wr      = cs & we;
  assign ctrl_wr = wr & (address == ADDR_CTRL);
  assign wr_a    = wr & (address == ADDR_A);
  assign rd_a    = cs & rd & (address == ADDR_A);

  assign pa_o   = pa_lat;
  assign pb_o   = pb_lat;
  assign pc_o   = pc_out;
  assign pa_oe  = ~a_in;
  assign pb_oe  = ~ctrl[CW_B_IN];
  assign intr_a = intr;

  // Mode 1 takes over three port C bits for handshake; the rest stay mode-0 I/O
  always_comb begin
    pc_own = 8'h00;
    pc_out = pc_lat;
    pc_oe  = {{4{~ctrl[CW_CH_IN]}}, {4{~ctrl[CW_CL_IN]}}};
    if (mode1) begin
      pc_own[PC_INTR] = 1'b1;
      pc_oe[PC_INTR]  = 1'b1;
      pc_out[PC_INTR] = intr;
      if (a_in) begin
        pc_own[PC_STB] = 1'b1;
        pc_own[PC_IBF] = 1'b1;
        pc_oe[PC_STB]  = 1'b0;
        pc_oe[PC_IBF]  = 1'b1;
        pc_out[PC_IBF] = ibf;
      end else begin
        pc_own[PC_ACK] = 1'b1;
        pc_own[PC_OBF] = 1'b1;
        pc_oe[PC_ACK]  = 1'b0;
        pc_oe[PC_OBF]  = 1'b1;
        pc_out[PC_OBF] = obf_n;
      end
    end
  end

  always_comb begin
    pc_rd = (pc_oe & pc_out) | (~pc_oe & pc_s);
    if (mode1) begin
      pc_rd[PC_INTR] = intr;
      if (a_in) begin
        pc_rd[PC_STB] = inte;
        pc_rd[PC_IBF] = ibf;
      end else begin
        pc_rd[PC_ACK] = inte;
        pc_rd[PC_OBF] = obf_n;
      end
    end
    dout = 8'h00;
    case (address)
      ADDR_A:  dout = m1_in ? a_in_lat : (a_in ? pa_s : pa_lat);
      ADDR_B:  dout = ctrl[CW_B_IN] ? pb_s : pb_lat;
      ADDR_C:  dout = pc_rd;
      default: dout = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= CTRL_RESET;
      pa_lat   <= 8'h00;
      pb_lat   <= 8'h00;
      pc_lat   <= 8'h00;
      a_in_lat <= 8'h00;
      inte     <= 1'b0;
      intr     <= 1'b0;
      ibf      <= 1'b0;
      obf_n    <= 1'b1;
    end else if (ctrl_wr) begin
      // A control write suppresses any handshake edge landing on the same clock
      if (din[CW_MODESET]) begin
        ctrl   <= din;
        pa_lat <= 8'h00;
        pb_lat <= 8'h00;
        pc_lat <= 8'h00;
        inte   <= 1'b0;
        intr   <= 1'b0;
        ibf    <= 1'b0;
        obf_n  <= 1'b1;
      end else if (mode1 && din[3:1] == (a_in ? PC_STB : PC_ACK)) begin
        inte <= din[0];
      end else begin
        pc_lat[din[3:1]] <= din[0];
      end
    end else begin
      if (wr_a)                          pa_lat <= din;
      if (wr && address == ADDR_B)       pb_lat <= din;
      if (wr && address == ADDR_C)       pc_lat <= (pc_lat & pc_own) | (din & ~pc_own);
      if (m1_in) begin
        if (pc_rise[PC_STB] && inte) intr <= 1'b1;
        if (rd_a) begin
          intr <= 1'b0;
          ibf  <= 1'b0;
        end
        if (pc_fall[PC_STB]) begin
          a_in_lat <= pa_s;
          ibf      <= 1'b1;
        end
      end
      if (m1_out) begin
        if (pc_rise[PC_ACK] && inte) intr <= 1'b1;
        if (pc_fall[PC_ACK])         obf_n <= 1'b1;
        if (wr_a) begin
          obf_n <= 1'b0;
          intr  <= 1'b0;
        end
      end
    end
  end

  assign unused_ok = ^{pa_rise, pa_fall, pb_rise, pb_fall, pc_rise[7], pc_rise[5:0],
                       pc_fall[7], pc_fall[5:0], ctrl[CW_MODESET], ctrl[CW_B_MODE]};

endmodule

// File: tb/tb_pia8255_gen.sv
// Randomized bench for pia8255_gen against a transaction-level model of the PIA registers.
module tb_pia8255_gen;

  localparam int SYNC_STAGES = 2;
`ifdef PIA8255_INSYNC_EN
  localparam int LAT = SYNC_STAGES;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0, reset_n = 1'b0, cs = 1'b0, we = 1'b0, rd = 1'b0;
  logic [1:0] address = 2'd0;
  logic [7:0] din = 8'h00, pa_i = 8'h00, pb_i = 8'h00, pc_i = 8'h50;
  logic [7:0] dout, pa_o, pb_o, pc_o, pc_oe;
  logic       pa_oe, pb_oe, intr_a;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pia8255_gen #(.SYNC_STAGES(SYNC_STAGES), .CTRL_RESET(8'h9B)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .rd(rd), .address(address),
    .din(din), .dout(dout), .pa_i(pa_i), .pb_i(pb_i), .pc_i(pc_i),
    .pa_o(pa_o), .pb_o(pb_o), .pc_o(pc_o), .pa_oe(pa_oe), .pb_oe(pb_oe),
    .pc_oe(pc_oe), .intr_a(intr_a));

  // Reference model state
  logic [7:0] m_ctrl, m_pa, m_pb, m_pc, m_alat;
  logic       m_inte, m_intr, m_ibf, m_obf;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic bit m1();
    return m_ctrl[6:5] == 2'b01;
  endfunction

  function automatic logic [7:0] own_mask();
    if (!m1()) return 8'h00;
    return m_ctrl[4] ? 8'h38 : 8'hC8;
  endfunction

  function automatic logic [7:0] exp_pc_oe();
    logic [7:0] oe;
    oe = {{4{~m_ctrl[3]}}, {4{~m_ctrl[0]}}};
    if (m1()) oe = m_ctrl[4] ? ((oe & 8'hC7) | 8'h28) : ((oe & 8'h37) | 8'h88);
    return oe;
  endfunction

  function automatic logic [7:0] exp_pc_o();
    logic [7:0] v;
    v = m_pc;
    if (m1()) begin
      v[3] = m_intr;
      if (m_ctrl[4]) v[5] = m_ibf;
      else           v[7] = m_obf;
    end
    return v;
  endfunction

  function automatic logic [7:0] exp_read(input logic [1:0] a);
    logic [7:0] v, oe;
    case (a)
      2'd0: v = (m1() && m_ctrl[4]) ? m_alat : (m_ctrl[4] ? pa_i : m_pa);
      2'd1: v = m_ctrl[1] ? pb_i : m_pb;
      2'd2: begin
        oe = exp_pc_oe();
        v = (oe & exp_pc_o()) | (~oe & pc_i);
        if (m1()) begin
          v[3] = m_intr;
          if (m_ctrl[4]) begin v[4] = m_inte; v[5] = m_ibf; end
          else           begin v[6] = m_inte; v[7] = m_obf; end
        end
      end
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_ctrl = 8'h9B; m_pa = 0; m_pb = 0; m_pc = 0; m_alat = 0;
    m_inte = 0; m_intr = 0; m_ibf = 0; m_obf = 1;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] own;
    own = own_mask();
    case (a)
      2'd0: begin
        m_pa = d;
        if (m1() && !m_ctrl[4]) begin m_obf = 0; m_intr = 0; end
      end
      2'd1: m_pb = d;
      2'd2: m_pc = (m_pc & own) | (d & ~own);
      default: begin
        if (d[7]) begin
          m_ctrl = d; m_pa = 0; m_pb = 0; m_pc = 0;
          m_inte = 0; m_intr = 0; m_ibf = 0; m_obf = 1;
        end else if (m1() && int'(d[3:1]) == (m_ctrl[4] ? 4 : 6)) m_inte = d[0];
        else m_pc[d[3:1]] = d[0];
      end
    endcase
  endtask

  task automatic model_read_a();
    if (m1() && m_ctrl[4]) begin m_intr = 0; m_ibf = 0; end
  endtask

  task automatic model_fall(input int b);
    if (m1() && m_ctrl[4] && b == 4) begin m_alat = pa_i; m_ibf = 1; end
    if (m1() && !m_ctrl[4] && b == 6) m_obf = 1;
  endtask

  task automatic model_rise(input int b);
    if (m1() && m_inte && ((m_ctrl[4] && b == 4) || (!m_ctrl[4] && b == 6))) m_intr = 1;
  endtask

  task automatic settle();
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1; we = 1; address = a; din = d;
    @(negedge clk);
    cs = 0; we = 0;
    model_write(a, d);
  endtask

  task automatic rd_check(input string tag);
    logic [7:0] e, v;
    e = exp_read(2'd0);
    @(negedge clk);
    cs = 1; rd = 1; address = 2'd0;
    #1 v = dout;
    @(negedge clk);
    cs = 0; rd = 0;
    check_val(tag, v, e);
    model_read_a();
  endtask

  task automatic hs_fall(input int b);
    @(negedge clk);
    pc_i[b] = 1'b0;
    settle();
    model_fall(b);
  endtask

  task automatic hs_rise(input int b);
    @(negedge clk);
    pc_i[b] = 1'b1;
    settle();
    model_rise(b);
  endtask

  // Drops handshake pin b so that its detected fall coincides with a bus access
  task automatic edge_with_op(input int b, input bit is_rd, input logic [1:0] a,
                              input logic [7:0] d, output logic [7:0] v);
    @(negedge clk);
    pc_i[b] = 1'b0;
    repeat (LAT) @(negedge clk);
    cs = 1; rd = is_rd; we = !is_rd; address = a; din = d;
    #1 v = dout;
    @(negedge clk);
    cs = 0; rd = 0; we = 0;
  endtask

  task automatic check_outs(input string tag);
    check_val({tag, ".pa_o"}, pa_o, m_pa);
    check_val({tag, ".pb_o"}, pb_o, m_pb);
    check_val({tag, ".pc_o"}, pc_o, exp_pc_o());
    check_val({tag, ".pc_oe"}, pc_oe, exp_pc_oe());
    check_val({tag, ".pa_oe"}, {7'd0, pa_oe}, {7'd0, !m_ctrl[4]});
    check_val({tag, ".pb_oe"}, {7'd0, pb_oe}, {7'd0, !m_ctrl[1]});
    check_val({tag, ".intr"}, {7'd0, intr_a}, {7'd0, m_intr});
  endtask

  task automatic check_all(input string tag);
    check_outs(tag);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1 check_val($sformatf("%s.rd%0d", tag, a), dout, exp_read(2'(a)));
    end
    address = 2'd0;
  endtask

  initial begin
    logic [7:0] r, v;
    bit inte_on;
    model_reset();
    pa_i = 8'h5A; pb_i = 8'hA5; pc_i = 8'h5E;
    repeat (2) @(negedge clk);
    check_outs("rst");
    reset_n = 1;
    settle();
    check_all("rst_rd");

    do_write(2'd3, 8'h82); do_write(2'd0, 8'hC3); check_all("m0_82");
    do_write(2'd3, 8'h05); check_all("bsr_set2");
    do_write(2'd3, 8'h04); check_all("bsr_clr2");

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          r = 8'($urandom); r[7] = 1'b1;
          if (r[6:5] == 2'b01) r[6] = 1'b1;
          do_write(2'd3, r);
        end
        1: begin r = 8'($urandom); r[7] = 1'b0; do_write(2'd3, r); end
        2: do_write(2'($urandom_range(0, 2)), 8'($urandom));
        3: begin
          @(negedge clk);
          pa_i = 8'($urandom); pb_i = 8'($urandom); pc_i = 8'($urandom);
          settle();
        end
        default: rd_check($sformatf("m0_rdA_%0d", it));
      endcase
      check_all($sformatf("m0_%0d", it));
    end

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pc_i = 8'($urandom) | 8'h50;
      settle();
      do_write(2'd3, 8'hB0); check_all($sformatf("m1i_set%0d", k));
      inte_on = (k != 1);
      do_write(2'd3, inte_on ? 8'h09 : 8'h08);
      do_write(2'd2, 8'($urandom)); check_all($sformatf("m1i_inte%0d", k));
      @(negedge clk);
      pa_i = 8'($urandom);
      settle();
      hs_fall(4); check_all($sformatf("m1i_fall%0d", k));
      hs_rise(4); check_all($sformatf("m1i_rise%0d", k));
      rd_check($sformatf("m1i_rdA%0d", k)); check_all($sformatf("m1i_rdclr%0d", k));
    end

    do_write(2'd3, 8'h09);
    @(negedge clk); pa_i = 8'h3C; settle();
    hs_fall(4); hs_rise(4); check_all("m1i_pend");
    @(negedge clk); pa_i = 8'($urandom); settle();
    r = exp_read(2'd0);
    edge_with_op(4, 1'b1, 2'd0, 8'h00, v);
    check_val("m1i_simul_rd", v, r);
    model_read_a(); model_fall(4);
    check_all("m1i_simul");
    hs_rise(4); check_all("m1i_simul_rise");

    @(negedge clk); pc_i[6] = 1'b1; settle();
    do_write(2'd3, 8'hA0); do_write(2'd3, 8'h0D); check_all("m1o_set");
    do_write(2'd0, 8'h77); check_all("m1o_wr");
    hs_fall(6); check_all("m1o_ackf");
    hs_rise(6); check_all("m1o_ackr");
    edge_with_op(6, 1'b0, 2'd0, 8'h5C, v);
    model_fall(6); model_write(2'd0, 8'h5C);
    check_all("m1o_simul");
    hs_rise(6); check_all("m1o_simul_rise");
    edge_with_op(6, 1'b0, 2'd3, 8'h0C, v);
    model_write(2'd3, 8'h0C);
    check_all("m1o_ctrlwin");
    hs_rise(6); check_all("m1o_ctrlwin_rise");

    do_write(2'd3, 8'hB0); do_write(2'd0, 8'hEE); do_write(2'd3, 8'h09);
    hs_fall(4); check_all("rst_mid_pre");
    @(negedge clk);
    #2 reset_n = 0;
    #1 model_reset();
    check_outs("rst_mid");
    @(negedge clk); reset_n = 1;
    settle();
    check_all("rst_mid_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pia8255_gen.md
# pia8255_gen

Clocked, parametrised successor to the Atom's PIA: three 8-bit ports (A, B, C), an 8255-style control register with per-group direction, port C bit set/reset, and 8255 mode-1 strobed handshake with interrupt on port A. It sits on the CPU bus at #B000–#B003 and drives or reads keyboard, graphics-mode, cassette and speaker lines through separate in/out/enable buses. Unlike the previous block, all state is synchronous to one system clock. Asynchronous port inputs can be synchronised.

## Interface
- SYNC_STAGES, 2: synchroniser depth for pa_i, pb_i, pc_i; legal range 2–4.
- CTRL_RESET, 8'h9B: control register value at reset (all ports input, mode 0).
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  1  chip select, qualifies we/rd.
- we  in  1  write strobe, one clk wide.
- rd  in  1  read strobe, one clk wide (side effects only).
- address  in  2  register select: 0=A, 1=B, 2=C, 3=control.
- din  in  8  write data.
- dout  out  8  read data, combinational from registered state.
- pa_i / pb_i / pc_i  in  8 each  port pin inputs.
- pa_o / pb_o / pc_o  out  8 each  port output latches.
- pa_oe / pb_oe  out  1 each  port drive enable.
- pc_oe  out  8  per-bit port C drive enable.
- intr_a  out  1  port A mode-1 interrupt (mirrors PC3).

## Operation
- Control register writes (address 3):
  - din[7]=1: mode set. Fields: [6:5] group A mode (01=mode 1, all others mode 0), [4] A input, [3] C high input, [1] B input, [0] C low input; [2] ignored (B is always mode 0).
  - A mode set clears pa_o, pb_o and pc_o, INTE_A, INTR and IBF, and sets OBF_n=1.
- din[7]=0: bit set/reset. Writes din[0] to pc_o bit din[3:1]. In mode 1 this targets INTE_A instead: bit 4 in input mode, bit 6 in output mode.
- Port writes (addresses 0–2) load the output latch regardless of direction. Writes to port C bits owned by mode 1 are ignored.
- Reads in mode 0:
  - Output ports return the latch.
  - Input ports return the synchronised pin value.
- Port C reads merge per half according to direction.
- Address 3 reads return 8'h00.
- Mode 1, A input:
  - PC4=STB_n (input), PC5=IBF (output), PC3=INTR (output).
  - STB_n falling edge latches pa_i into the A input latch and sets IBF.
  - STB_n rising edge with INTE_A set sets INTR.
  - A read of port A (cs&rd, address 0) returns the latch and clears INTR and IBF on that edge.
- Mode 1, A output:
  - PC7=OBF_n (output), PC6=ACK_n (input), PC3=INTR.
  - A write to port A clears INTR and drives OBF_n=0.
  - ACK_n falling edge sets OBF_n=1.
  - ACK_n rising edge with INTE_A set sets INTR.
- Port C status reads in mode 1: handshake bits return their live status (PC3 INTR, PC4/PC6 INTE_A, PC5 IBF, PC7 OBF_n). Remaining bits follow mode-0 rules.
- Simultaneous events:
  - Port A write and ACK_n falling edge on the same edge: OBF_n=0 (write wins).
  - STB_n falling edge and port A read on the same edge: new data latched, IBF stays 1, INTR cleared.
  - Control write and any handshake edge on the same edge: control write wins.

## Timing
- Reset values:
  - Control register = CTRL_RESET.
  - pa_o, pb_o, pc_o = 0; pa_oe, pb_oe = 0; pc_oe = 0 for CTRL_RESET.
  - intr_a = 0, IBF = 0, OBF_n = 1, INTE_A = 0.
  - Synchroniser and edge-detect flops are cleared to 1 for handshake inputs and to 0 otherwise.
- Write latency: outputs update on the clk edge where cs&we. The new value is visible on pins one cycle after the strobe.
- Input latency: a pin change appears in dout and at the edge detectors SYNC_STAGES cycles later. Edge detection adds one register.
- Strobe width: STB_n and ACK_n pulses must be ≥ SYNC_STAGES+1 clk to be detected.
- dout is valid in the same cycle that address changes. No wait states.
- Asserting reset_n low mid-handshake aborts it immediately to reset values.

## Configuration
- PIA8255_INSYNC_EN defined: inputs pass through SYNC_STAGES flip-flops before use.
- PIA8255_INSYNC_EN undefined: inputs are used directly. Edge detectors keep their single history register, so input latency is 0 cycles to dout and 1 cycle to edge events.

## Structure
- Package pia8255_pkg holds:
  - address constants ADDR_A/B/C/CTRL;
  - control-word bit positions;
  - mode-1 port C bit indices (PC_INTR=3, PC_STB=4, PC_IBF=5, PC_ACK=6, PC_OBF=7);
  - default CTRL_RESET.
- One sub-module, pia_sync: parametrised-width synchroniser plus rise/fall edge detector, instantiated once per input port. The PIA8255_INSYNC_EN selection lives inside it.

## Test plan
- Reset, then read address 0 with pa_i=8'h5A -> dout=8'h5A after SYNC_STAGES clks; pa_oe=0, intr_a=0.
- Write control 8'h82, then write 8'hC3 to A -> pa_oe=1, pa_o=8'hC3 one clk later; pb_oe=0.
- Mode 0 with C low output, write control 8'h05 then 8'h04 -> pc_o[2]=1 then 0; other pc_o bits unchanged.
- Control 8'hB0, INTE via 8'h09, pa_i=8'h3C, pulse PC4 low for 4 clks:
  - at STB_n fall -> IBF=1; at STB_n rise -> intr_a=1;
  - then read A -> dout=8'h3C, and intr_a and IBF clear on that edge.
- Control 8'hA0, INTE via 8'h0D, write A 8'h77:
  - -> pc_o[7]=0;
  - pulse PC6 low -> pc_o[7]=1; on ACK_n rise -> intr_a=1;
  - a write on the same edge as the ACK_n fall -> pc_o[7] stays 0.
- Assert reset_n mid-handshake with IBF=1 -> IBF, intr_a and pa_o clear asynchronously and the control register returns to 8'h9B.
